seg7_scan_decoder: RTL
======================

// Module: seg7_scan_decoder
// PURPOSE
//  Decodes a multiplexed 4-digit, active-low seven-segment bus (segments/anodes/dp) back into binary.
//  Serves as the loopback checker for the binary-to-seven-segment display driver on the board.
//  Captures one full scan (digit 0..3) and converts the decimal digits to a 14-bit value.
//  Flags illegal glyphs and out-of-order scans.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive clk cycles {an,segmentDisplay,dp} must hold before a digit is sampled (>=1)
// PORTS
//  clk             in   1   single system clock; all state on posedge clk
//  reset           in   1   asynchronous, active-high reset
//  segmentDisplay  in   7   segment bus, active-low, bit6=g .. bit0=a
//  an              in   4   anode select, active-low; 1110=ones, 1101=tens, 1011=hundreds, 0111=thousands
//  dp              in   1   decimal point, active-low
//  value           out  14  last good decoded value, 0..9999
//  bcd             out  16  last good digits {thou,hund,ten,one}, 4 bits each
//  value_valid     out  1   1-cycle pulse: value/bcd updated this cycle
//  pattern_err     out  1   1-cycle pulse: frame discarded, illegal glyph or dp lit
//  frame_abort     out  1   1-cycle pulse: frame discarded, scan order broken
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, stability counter and digit registers 0. Takes effect immediately, mid-frame included. No output pulses for the aborted frame.
//  Stability filter:
//   - counter clears whenever the {an,segmentDisplay,dp} differs from the previous cycle's value.
//   - a selection is sampled exactly once, on the cycle the counter reaches STABLE_CYCLES.
//   - it is not resampled until an changes.
//  Glyph decode (segmentDisplay -> digit):
//   - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
//   - any other pattern is illegal.
//   - dp=0 at sample time is illegal.
//  Frame error flag: any illegal sample sets a per-frame bad flag; capture order is unaffected.
//  FSM states: IDLE, CAP1, CAP2, CAP3, CONV, DONE.
//   IDLE: wait for a sample with an=1110; store ones -> CAP1.
//   CAP1/CAP2/CAP3: the next sample must carry an=1101/1011/0111 respectively; store tens/hundreds/thousands.
//    - CAP3 on that sample -> CONV.
//    - Sample with an=1110: restart the frame with ones; frame_abort pulses; stays/returns to CAP1.
//    - Sample with any other an value (0000, 1111, wrong digit): frame_abort pulses -> IDLE.
//   CONV: 4 cycles; acc = acc*10 + digit, thousands first, acc cleared on entry.
//    - *10 is implemented as (acc<<3)+(acc<<1); acc is 14 bits and never exceeds 9999.
//    - Inputs are still filtered but ignored.
//   DONE: one cycle, then -> IDLE.
//    - Bad flag clear: value<=acc, bcd<=digits, value_valid=1.
//    - Bad flag set: value/bcd held, pattern_err=1.
//  Latency: value_valid/pattern_err assert exactly 5 clk cycles after the edge sampling the thousands digit.
//  Continuous scanning: a new ones digit sampled during CONV/DONE is lost; the next frame is caught on the following scan.
//  An unused FSM encoding returns to IDLE on the next edge with no output pulse.
// TESTING
//  1. Scan 1234 (ones..thousands glyphs, each held 8 clk) -> value=1234, bcd=16'h1234, value_valid 1 cycle, 5 clk after thousands sample.
//  2. Scan 9999, then 0000 -> value=9999/bcd=16'h9999, then value=0/bcd=16'h0000; two value_valid pulses.
//  3. Scan 5678 with tens segmentDisplay=1111111 -> pattern_err pulse; value stays at prior 1234; no value_valid.
//  4. an sequence 1110 -> 1011 (tens skipped) -> frame_abort pulse, FSM IDLE; next clean scan of 42 -> value=42.
//  5. Mid-digit 2-cycle glitch (segments 0000000, STABLE_CYCLES=4) during a 3 digit -> ignored, value=3 in that position.
//  6. Assert reset while in CAP2 -> all outputs 0 immediately; a full scan of 7 afterwards -> value=7.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed seven-segment bus and the decoded result for the loopback checker.
// master = side driving the display bus; slave = the decoder.
interface seg7_scan_decoder_if;
   logic [6:0]  segmentDisplay;
   logic [3:0]  an;
   logic        dp;
   logic [13:0] value;
   logic [15:0] bcd;
   logic        value_valid;
   logic        pattern_err;
   logic        frame_abort;

   modport master (
      output segmentDisplay, an, dp,
      input  value, bcd, value_valid, pattern_err, frame_abort
   );

   modport slave (
      input  segmentDisplay, an, dp,
      output value, bcd, value_valid, pattern_err, frame_abort
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Loopback checker: watches a 4-digit active-low multiplexed seven-segment bus,
// captures one ordered scan (ones..thousands) and rebuilds the binary value.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input logic                 clk,
   input logic                 reset,
   seg7_scan_decoder_if.slave  bus
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, CAP1, CAP2, CAP3, CONV, DONE} state_t;

   state_t          state_q, state_d;
   logic [11:0]     cur, prev_q;
   logic [CW-1:0]   cnt_q;
   logic            sampled_q;
   logic            same, sample;
   logic [3:0]      s_an;
   logic [6:0]      s_seg;
   logic [3:0]      s_digit;
   logic            s_ill;
   logic            st_ones, st_tens, st_hund, st_thou, abort, conv_en, fin;
   logic [3:0][3:0] dig_q;
   logic            bad_q;
   logic [13:0]     acc_q;
   logic [1:0]      conv_idx_q;
   logic [13:0]     value_q;
   logic [15:0]     bcd_q;
   logic            valid_q, perr_q, abort_q;

   assign cur    = {bus.an, bus.segmentDisplay, bus.dp};
   assign same   = (cur == prev_q);
   // One sample per selection: fires as the hold count reaches STABLE_CYCLES,
   // and the sampled flag blocks re-sampling until the anode changes.
   assign sample = same && (cnt_q == CW'(STABLE_CYCLES - 1)) && !sampled_q;
   assign s_an   = prev_q[11:8];
   assign s_seg  = prev_q[7:1];

   // Stability filter: history register, hold counter, sampled-once flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q    <= '0;
         cnt_q     <= '0;
         sampled_q <= 1'b0;
      end else begin
         prev_q <= cur;
         if (!same)
            cnt_q <= '0;
         else if (cnt_q != CW'(STABLE_CYCLES))
            cnt_q <= cnt_q + CW'(1);
         if (cur[11:8] != prev_q[11:8])
            sampled_q <= 1'b0;
         else if (sample)
            sampled_q <= 1'b1;
      end
   end

   // Glyph lookup; dp lit (low) also makes a sample illegal.
   always_comb begin
      s_digit = 4'd0;
      s_ill   = 1'b0;
      case (s_seg)
         7'b1000000: s_digit = 4'd0;
         7'b1111001: s_digit = 4'd1;
         7'b0100100: s_digit = 4'd2;
         7'b0110000: s_digit = 4'd3;
         7'b0011001: s_digit = 4'd4;
         7'b0010010: s_digit = 4'd5;
         7'b0000010: s_digit = 4'd6;
         7'b1111000: s_digit = 4'd7;
         7'b0000000: s_digit = 4'd8;
         7'b0010000: s_digit = 4'd9;
         default:    s_ill   = 1'b1;
      endcase
      if (!prev_q[0]) s_ill = 1'b1;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and datapath strobes.
   always_comb begin
      state_d = state_q;
      st_ones = 1'b0;
      st_tens = 1'b0;
      st_hund = 1'b0;
      st_thou = 1'b0;
      abort   = 1'b0;
      conv_en = 1'b0;
      fin     = 1'b0;
      case (state_q)
         IDLE: if (sample && s_an == 4'b1110) begin
            st_ones = 1'b1;
            state_d = CAP1;
         end
         CAP1, CAP2, CAP3: if (sample) begin
            if (state_q == CAP1 && s_an == 4'b1101) begin
               st_tens = 1'b1;
               state_d = CAP2;
            end else if (state_q == CAP2 && s_an == 4'b1011) begin
               st_hund = 1'b1;
               state_d = CAP3;
            end else if (state_q == CAP3 && s_an == 4'b0111) begin
               st_thou = 1'b1;
               state_d = CONV;
            end else if (s_an == 4'b1110) begin
               abort   = 1'b1;
               st_ones = 1'b1;
               state_d = CAP1;
            end else begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         CONV: begin
            conv_en = 1'b1;
            if (conv_idx_q == 2'd3) state_d = DONE;
         end
         DONE: begin
            fin     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Digit capture, decimal accumulation (thousands first) and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dig_q      <= '0;
         bad_q      <= 1'b0;
         acc_q      <= '0;
         conv_idx_q <= '0;
         value_q    <= '0;
         bcd_q      <= '0;
         valid_q    <= 1'b0;
         perr_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         abort_q <= abort;
         if (st_ones) begin dig_q[0] <= s_digit; bad_q <= s_ill;         end
         if (st_tens) begin dig_q[1] <= s_digit; bad_q <= bad_q | s_ill; end
         if (st_hund) begin dig_q[2] <= s_digit; bad_q <= bad_q | s_ill; end
         if (st_thou) begin
            dig_q[3]   <= s_digit;
            bad_q      <= bad_q | s_ill;
            acc_q      <= '0;
            conv_idx_q <= '0;
         end
         if (conv_en) begin
            acc_q      <= (acc_q << 3) + (acc_q << 1) + {10'd0, dig_q[2'd3 - conv_idx_q]};
            conv_idx_q <= conv_idx_q + 2'd1;
         end
         if (fin) begin
            if (bad_q) perr_q <= 1'b1;
            else begin
               value_q <= acc_q;
               bcd_q   <= dig_q;
               valid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.value       = value_q;
   assign bus.bcd         = bcd_q;
   assign bus.value_valid = valid_q;
   assign bus.pattern_err = perr_q;
   assign bus.frame_abort = abort_q;
endmodule
